m_mc_core: RTL and testbench
============================

# m_mc_core

Parametrised multi-cycle RV32I-subset core, the successor to the two-phase single-cycle CPU top. It replaces the free-running `$finish`-driven datapath with an explicit FSM (fetch / decode / execute / memory / write-back) and decouples instruction and data memories behind request/valid handshakes, so wait-stated memories can be attached. It sits directly under the simulation top, with `imem` and a data memory model as peers.

## Interface
- `XLEN`, 32: datapath and register width; must be ≥ 32.
- `NREGS`, 32: architectural registers, power of two, 2..32; x0 hard-wired 0.
- `RESET_PC`, 0: PC value loaded on reset.
- `HALT_REG`, 30: a write-back to this register index sets halt.

Ports:
- `w_clk` in 1: clock; all state updates on rising edge.
- `w_rst` in 1: asynchronous, active-high reset.
- `w_imem_req` out 1: instruction fetch request.
- `w_imem_addr` out XLEN: byte address, equal to PC; word aligned.
- `w_imem_valid` in 1: `w_imem_rdata` valid this cycle.
- `w_imem_rdata` in 32: instruction word.
- `w_dmem_req` out 1: data access request.
- `w_dmem_we` out 1: 1 = store, 0 = load.
- `w_dmem_addr` out XLEN: byte address (rs1 + imm).
- `w_dmem_wdata` out XLEN: store data (rs2).
- `w_dmem_valid` in 1: load data ready or store accepted.
- `w_dmem_rdata` in XLEN: load data.
- `w_pc` out XLEN: current PC.
- `w_halted` out 1: core stopped.
- `w_illegal` out 1: halt was caused by an unsupported instruction.
- `w_instret` out 32: retired-instruction count; wraps modulo 2^32.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH
  - Drive `w_imem_req`=1 with `w_imem_addr`=PC.
  - When `w_imem_valid` is sampled high, latch the instruction and go to DECODE.
  - Otherwise stay in FETCH and hold the request.
- DECODE
  - Read rs1/rs2 (x0 reads 0).
  - Generate the sign-extended immediate: I-type `inst[31:20]`; S-type `{inst[31:25],inst[11:7]}`; B-type `{inst[31],inst[7],inst[30:25],inst[11:8],0}`.
  - Latch operands and immediate.
  - An unsupported opcode/funct goes to HALT with `w_illegal`=1.
- Supported instructions: ADDI, ADD, SUB (funct7 bit 5), LW, SW; BEQ and BNE only under the macro below.
- EXEC
  - ALU computes an XLEN-bit add/sub; carry is discarded.
  - ALU-op → WB.
  - LW/SW → MEM, with address = rs1 + imm.
  - Branch → PC ← taken ? PC+imm : PC+4; instret++; → FETCH.
- MEM
  - Drive `w_dmem_req`=1 with stable addr/we/wdata until `w_dmem_valid` is sampled high.
  - Load → latch `w_dmem_rdata` and go to WB.
  - Store → PC+4, instret++, → FETCH.
- WB
  - Write rd if rd≠0.
  - PC ← PC+4; instret++.
  - If rd==`HALT_REG`, go to HALT; else go to FETCH.
  - Writes to indices ≥ `NREGS` are dropped.
- HALT: absorbing state; all requests 0; PC frozen; exits only on reset.
- PC increments wrap modulo 2^XLEN. Misaligned PC or data address is not checked; the low 2 bits are passed through unchanged.

## Timing
- Reset values: PC=`RESET_PC`, state=FETCH, all registers 0, `w_imem_req`=0 in the reset cycle, `w_dmem_req`=0, `w_dmem_we`=0, `w_halted`=0, `w_illegal`=0, `w_instret`=0.
- Requests are combinational functions of state; the address is registered.
- Cycles per instruction with zero-wait memory (valid asserted in the request cycle):
  - ALU op: 4.
  - LW: 5.
  - SW: 4.
  - Branch: 3.
- Each imem or dmem wait cycle adds exactly 1 cycle.
- A valid seen while req=0 is ignored.
- Register write-back is visible to the DECODE of the next instruction; no bypass is needed.
- Reset asserted mid-transaction abandons the outstanding request immediately (async). Memories must drop it.
- `w_halted` rises in the cycle after the halting WB or DECODE edge. `w_instret` includes the halting instruction for a write to `HALT_REG`, but not for an illegal instruction.

## Configuration
- `MC_CORE_BRANCH_EN` defined: BEQ/BNE decoded, B-type immediate generated, branch path in EXEC.
- Undefined: opcode 1100011 is illegal → HALT with `w_illegal`=1; the B-immediate logic is absent.

## Test plan
- Zero-wait memories; program: addi x1,x0,5; addi x2,x1,-3; add x3,x1,x2; addi x30,x0,1.
  - Required: x1=5, x2=2, x3=7.
  - `w_halted`=1 after 16 cycles; `w_instret`=4; PC=12.
- sw x3,8(x0) then lw x4,8(x0), with 2 wait cycles on each dmem access.
  - Required: dmem sees addr 8, we=1, wdata=7; then x4=7.
  - Request held 3 cycles each time; CPI 6 for SW and 7 for LW.
- addi x0,x0,9 followed by add x5,x0,x0.
  - Required: x0 stays 0; x5=0.
- Branch taken/not-taken (macro on).
  - beq x1,x1,+8 → PC+8 in 3 cycles.
  - bne x1,x1,+8 → PC+4.
  - Macro off: the same word gives `w_illegal`=1, `w_halted`=1, instret unchanged.
- Illegal opcode 0x0000007F at PC 0.
  - Required: HALT, `w_illegal`=1, `w_instret`=0; no further requests.
- Assert `w_rst` during MEM wait of a load.
  - Required: `w_dmem_req` drops in the same cycle, PC=`RESET_PC`, x-regs=0, fetch restarts after deassertion.

Source files
------------

// File: rtl/m_mc_core_if.sv
// m_mc_core_if: instruction/data memory handshake bundle.
// The core drives requests as master; memory models attach as slave.
interface m_mc_core_if #(
    parameter int XLEN = 32
);
    logic            w_imem_req;
    logic [XLEN-1:0] w_imem_addr;
    logic            w_imem_valid;
    logic [31:0]     w_imem_rdata;

    logic            w_dmem_req;
    logic            w_dmem_we;
    logic [XLEN-1:0] w_dmem_addr;
    logic [XLEN-1:0] w_dmem_wdata;
    logic            w_dmem_valid;
    logic [XLEN-1:0] w_dmem_rdata;

    modport master (
        output w_imem_req,
        output w_imem_addr,
        input  w_imem_valid,
        input  w_imem_rdata,
        output w_dmem_req,
        output w_dmem_we,
        output w_dmem_addr,
        output w_dmem_wdata,
        input  w_dmem_valid,
        input  w_dmem_rdata
    );

    modport slave (
        input  w_imem_req,
        input  w_imem_addr,
        output w_imem_valid,
        output w_imem_rdata,
        input  w_dmem_req,
        input  w_dmem_we,
        input  w_dmem_addr,
        input  w_dmem_wdata,
        output w_dmem_valid,
        output w_dmem_rdata
    );
endinterface

// File: rtl/m_mc_core.sv
// m_mc_core: multi-cycle RV32I-subset core (ADDI/ADD/SUB/LW/SW).
// Define MC_CORE_BRANCH_EN to add BEQ/BNE; otherwise opcode 1100011 is illegal.
module m_mc_core #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              HALT_REG = 30
) (
    input  logic             w_clk,
    input  logic             w_rst,
    m_mc_core_if.master      bus,
    output logic [XLEN-1:0]  w_pc,
    output logic             w_halted,
    output logic             w_illegal,
    output logic [31:0]      w_instret
);

    localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t          state;
    logic [31:0]     inst_q;
    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] imm_q;
    logic [XLEN-1:0] res_q;
    logic [XLEN-1:0] daddr_q;
    logic [XLEN-1:0] dwdata_q;
    logic [4:0]      rd_q;
    logic            dwe_q;
    logic            op_rr_q;
    logic            op_sub_q;
    logic            op_ld_q;
    logic            op_st_q;
`ifdef MC_CORE_BRANCH_EN
    logic            op_br_q;
    logic            op_bne_q;
`endif
    logic            halted_q;
    logic            illegal_q;
    logic [31:0]     instret_q;

    // decode fields
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            d_addi;
    logic            d_rr;
    logic            d_lw;
    logic            d_sw;
    logic            d_br;
    logic            d_legal;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
`ifdef MC_CORE_BRANCH_EN
    logic [XLEN-1:0] imm_b;
`endif
    logic [XLEN-1:0] d_imm;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] pc_inc;

    assign opc = inst_q[6:0];
    assign f3  = inst_q[14:12];
    assign f7  = inst_q[31:25];
    assign rs1 = inst_q[19:15];
    assign rs2 = inst_q[24:20];

    assign imm_i = {{(XLEN-12){inst_q[31]}}, inst_q[31:20]};
    assign imm_s = {{(XLEN-12){inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
`ifdef MC_CORE_BRANCH_EN
    assign imm_b = {{(XLEN-13){inst_q[31]}}, inst_q[31], inst_q[7],
                    inst_q[30:25], inst_q[11:8], 1'b0};
`endif

    // instruction classification; anything unmatched is illegal
    always_comb begin
        d_addi = (opc == 7'b0010011) && (f3 == 3'b000);
        d_rr   = (opc == 7'b0110011) && (f3 == 3'b000)
               && ((f7 == 7'b0000000) || (f7 == 7'b0100000));
        d_lw   = (opc == 7'b0000011) && (f3 == 3'b010);
        d_sw   = (opc == 7'b0100011) && (f3 == 3'b010);
`ifdef MC_CORE_BRANCH_EN
        d_br   = (opc == 7'b1100011) && ((f3 == 3'b000) || (f3 == 3'b001));
`else
        d_br   = 1'b0;
`endif
        d_legal = d_addi | d_rr | d_lw | d_sw | d_br;
    end

    // immediate select by format
    always_comb begin
        d_imm = imm_i;
        unique case (1'b1)
            d_sw: d_imm = imm_s;
`ifdef MC_CORE_BRANCH_EN
            d_br: d_imm = imm_b;
`endif
            default: d_imm = imm_i;
        endcase
    end

    // register read; x0 and unimplemented indices read as zero
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != 5'd0 && int'(rs1) < NREGS) rs1_val = regs[rs1[RW-1:0]];
        if (rs2 != 5'd0 && int'(rs2) < NREGS) rs2_val = regs[rs2[RW-1:0]];
    end

    // add/sub ALU, carry out is dropped
    always_comb begin
        alu_b   = op_rr_q ? b_q : imm_q;
        alu_res = op_sub_q ? (a_q - alu_b) : (a_q + alu_b);
        pc_inc  = pc_q + XLEN'(4);
    end

    // main FSM with datapath registers and register file
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            state     <= S_FETCH;
            inst_q    <= '0;
            pc_q      <= RESET_PC;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            res_q     <= '0;
            daddr_q   <= '0;
            dwdata_q  <= '0;
            rd_q      <= '0;
            dwe_q     <= 1'b0;
            op_rr_q   <= 1'b0;
            op_sub_q  <= 1'b0;
            op_ld_q   <= 1'b0;
            op_st_q   <= 1'b0;
`ifdef MC_CORE_BRANCH_EN
            op_br_q   <= 1'b0;
            op_bne_q  <= 1'b0;
`endif
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            instret_q <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (bus.w_imem_valid) begin
                        inst_q <= bus.w_imem_rdata;
                        state  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!d_legal) begin
                        halted_q  <= 1'b1;
                        illegal_q <= 1'b1;
                        state     <= S_HALT;
                    end else begin
                        a_q      <= rs1_val;
                        b_q      <= rs2_val;
                        imm_q    <= d_imm;
                        rd_q     <= inst_q[11:7];
                        op_rr_q  <= d_rr;
                        op_sub_q <= d_rr & f7[5];
                        op_ld_q  <= d_lw;
                        op_st_q  <= d_sw;
`ifdef MC_CORE_BRANCH_EN
                        op_br_q  <= d_br;
                        op_bne_q <= f3[0];
`endif
                        state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (op_ld_q || op_st_q) begin
                        daddr_q  <= a_q + imm_q;
                        dwdata_q <= b_q;
                        dwe_q    <= op_st_q;
                        state    <= S_MEM;
`ifdef MC_CORE_BRANCH_EN
                    end else if (op_br_q) begin
                        pc_q      <= ((a_q == b_q) ^ op_bne_q)
                                   ? (pc_q + imm_q) : pc_inc;
                        instret_q <= instret_q + 32'd1;
                        state     <= S_FETCH;
`endif
                    end else begin
                        res_q <= alu_res;
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (bus.w_dmem_valid) begin
                        if (dwe_q) begin
                            pc_q      <= pc_inc;
                            instret_q <= instret_q + 32'd1;
                            state     <= S_FETCH;
                        end else begin
                            res_q <= bus.w_dmem_rdata;
                            state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (rd_q != 5'd0 && int'(rd_q) < NREGS)
                        regs[rd_q[RW-1:0]] <= res_q;
                    instret_q <= instret_q + 32'd1;
                    // a halting write leaves PC on the halting instruction
                    if (rd_q == 5'(HALT_REG)) begin
                        halted_q <= 1'b1;
                        state    <= S_HALT;
                    end else begin
                        pc_q  <= pc_inc;
                        state <= S_FETCH;
                    end
                end
                S_HALT: state <= S_HALT;
                default: state <= S_HALT;
            endcase
        end
    end

    // requests follow state but drop as soon as reset is asserted
    assign bus.w_imem_req   = (state == S_FETCH) && !w_rst;
    assign bus.w_imem_addr  = pc_q;
    assign bus.w_dmem_req   = (state == S_MEM) && !w_rst;
    assign bus.w_dmem_we    = dwe_q;
    assign bus.w_dmem_addr  = daddr_q;
    assign bus.w_dmem_wdata = dwdata_q;

    assign w_pc      = pc_q;
    assign w_halted  = halted_q;
    assign w_illegal = illegal_q;
    assign w_instret = instret_q;

endmodule

// File: tb/tb_m_mc_core.sv
// tb_m_mc_core: directed programs against m_mc_core with
// wait-stated instruction/data memory models.
module tb_m_mc_core;

    logic        w_clk;
    logic        w_rst;
    logic [31:0] w_pc;
    logic        w_halted;
    logic        w_illegal;
    logic [31:0] w_instret;

    m_mc_core_if #(.XLEN(32)) bus ();

    m_mc_core dut (
        .w_clk     (w_clk),
        .w_rst     (w_rst),
        .bus       (bus.master),
        .w_pc      (w_pc),
        .w_halted  (w_halted),
        .w_illegal (w_illegal),
        .w_instret (w_instret)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    logic [31:0] imem [16];
    logic [31:0] dmem [16];
    int iwait;
    int dwait;
    int icnt;
    int dcnt;
    int cyc;
    int n_req;
    int n_dacc;
    logic [31:0] prev_ret;
    int ret_cyc [16];
    logic [31:0] ret_pc [16];
    logic [31:0] dacc_addr [4];
    logic        dacc_we [4];
    logic [31:0] dacc_wdata [4];
    int          dacc_hold [4];

    int n_cmp;
    int n_err;

    assign bus.w_imem_valid = bus.w_imem_req && (icnt >= iwait);
    assign bus.w_imem_rdata = imem[bus.w_imem_addr[5:2]];
    assign bus.w_dmem_valid = bus.w_dmem_req && (dcnt >= dwait);
    assign bus.w_dmem_rdata = dmem[bus.w_dmem_addr[5:2]];

    // wait-state counters and data memory writes
    always @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            icnt <= 0;
            dcnt <= 0;
            cyc  <= 0;
        end else begin
            cyc  <= cyc + 1;
            icnt <= (bus.w_imem_req && !bus.w_imem_valid) ? icnt + 1 : 0;
            dcnt <= (bus.w_dmem_req && !bus.w_dmem_valid) ? dcnt + 1 : 0;
            if (bus.w_dmem_req && bus.w_dmem_valid && bus.w_dmem_we)
                dmem[bus.w_dmem_addr[5:2]] <= bus.w_dmem_wdata;
        end
    end

    // observation log sampled mid-cycle
    always @(negedge w_clk) begin
        if (w_rst) begin
            prev_ret <= '0;
            n_dacc   <= 0;
        end else begin
            if (bus.w_imem_req || bus.w_dmem_req) n_req <= n_req + 1;
            if (bus.w_dmem_req && bus.w_dmem_valid) begin
                dacc_addr[n_dacc[1:0]]  <= bus.w_dmem_addr;
                dacc_we[n_dacc[1:0]]    <= bus.w_dmem_we;
                dacc_wdata[n_dacc[1:0]] <= bus.w_dmem_wdata;
                dacc_hold[n_dacc[1:0]]  <= dcnt + 1;
                n_dacc <= n_dacc + 1;
            end
            if (w_instret != prev_ret) begin
                ret_cyc[w_instret[3:0]] <= cyc;
                ret_pc[w_instret[3:0]]  <= w_pc;
                prev_ret <= w_instret;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] e_i(input int rd, input int rs1,
                                        input int imm, input logic [6:0] opc,
                                        input logic [2:0] f3);
        logic [11:0] im;
        im = imm[11:0];
        return {im, 5'(rs1), f3, 5'(rd), opc};
    endfunction

    function automatic logic [31:0] e_addi(input int rd, input int rs1,
                                           input int imm);
        return e_i(rd, rs1, imm, 7'h13, 3'd0);
    endfunction

    function automatic logic [31:0] e_lw(input int rd, input int rs1,
                                         input int imm);
        return e_i(rd, rs1, imm, 7'h03, 3'd2);
    endfunction

    function automatic logic [31:0] e_r(input int rd, input int rs1,
                                        input int rs2, input logic [6:0] f7);
        return {f7, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] e_sw(input int rs2, input int rs1,
                                         input int imm);
        logic [11:0] im;
        im = imm[11:0];
        return {im[11:5], 5'(rs2), 5'(rs1), 3'd2, im[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] e_b(input int rs1, input int rs2,
                                        input int imm, input logic [2:0] f3);
        logic [12:0] b;
        b = imm[12:0];
        return {b[12], b[10:5], 5'(rs2), 5'(rs1), f3, b[4:1], b[11], 7'h63};
    endfunction

    task automatic clr_imem();
        for (int i = 0; i < 16; i++) imem[i] = 32'h0000007F;
    endtask

    task automatic do_reset();
        w_rst = 1'b1;
        repeat (2) @(posedge w_clk);
        @(negedge w_clk);
        w_rst = 1'b0;
    endtask

    task automatic wait_halt(input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge w_clk);
            #1;
            if (w_halted) begin
                n = k;
                break;
            end
        end
        if (n < 0) chk("halt_timeout", 32'd0, 32'd1);
    endtask

    int ncyc;
    int req_snap;

    initial begin
        n_cmp = 0;
        n_err = 0;
        n_req = 0;
        iwait = 0;
        dwait = 0;
        w_rst = 1'b1;
        for (int i = 0; i < 16; i++) dmem[i] = 32'h0;
        clr_imem();

        // A: ALU program, zero-wait
        imem[0] = e_addi(1, 0, 5);
        imem[1] = e_addi(2, 1, -3);
        imem[2] = e_r(3, 1, 2, 7'h00);
        imem[3] = e_addi(30, 0, 1);
        #1;
        chk("rst_imem_req", {31'd0, bus.w_imem_req}, 32'd0);
        chk("rst_dmem_req", {31'd0, bus.w_dmem_req}, 32'd0);
        chk("rst_pc", w_pc, 32'd0);
        chk("rst_instret", w_instret, 32'd0);
        chk("rst_halted", {31'd0, w_halted}, 32'd0);
        do_reset();
        wait_halt(60, ncyc);
        chk("A_cycles", ncyc, 32'd16);
        chk("A_x1", dut.regs[1], 32'd5);
        chk("A_x2", dut.regs[2], 32'd2);
        chk("A_x3", dut.regs[3], 32'd7);
        chk("A_x30", dut.regs[30], 32'd1);
        chk("A_instret", w_instret, 32'd4);
        chk("A_pc", w_pc, 32'd12);
        chk("A_illegal", {31'd0, w_illegal}, 32'd0);
        chk("A_imem_req", {31'd0, bus.w_imem_req}, 32'd0);

        // B: store then load, 2 dmem wait cycles
        clr_imem();
        imem[0] = e_addi(3, 0, 7);
        imem[1] = e_sw(3, 0, 8);
        imem[2] = e_lw(4, 0, 8);
        imem[3] = e_addi(30, 0, 1);
        dwait = 2;
        do_reset();
        wait_halt(80, ncyc);
        chk("B_st_addr", dacc_addr[0], 32'd8);
        chk("B_st_we", {31'd0, dacc_we[0]}, 32'd1);
        chk("B_st_wdata", dacc_wdata[0], 32'd7);
        chk("B_st_hold", dacc_hold[0], 32'd3);
        chk("B_ld_we", {31'd0, dacc_we[1]}, 32'd0);
        chk("B_ld_hold", dacc_hold[1], 32'd3);
        chk("B_x4", dut.regs[4], 32'd7);
        chk("B_sw_cpi", ret_cyc[2] - ret_cyc[1], 32'd6);
        chk("B_lw_cpi", ret_cyc[3] - ret_cyc[2], 32'd7);
        chk("B_instret", w_instret, 32'd4);

        // C: x0 writes ignored, SUB, 1 imem wait cycle
        clr_imem();
        imem[0] = e_addi(5, 0, 3);
        imem[1] = e_addi(0, 0, 9);
        imem[2] = e_r(6, 0, 5, 7'h20);
        imem[3] = e_r(5, 0, 0, 7'h00);
        imem[4] = e_addi(30, 0, 1);
        iwait = 1;
        dwait = 0;
        do_reset();
        wait_halt(80, ncyc);
        chk("C_cycles", ncyc, 32'd25);
        chk("C_x0", dut.regs[0], 32'd0);
        chk("C_x6_sub", dut.regs[6], 32'hFFFF_FFFD);
        chk("C_x5", dut.regs[5], 32'd0);
        chk("C_instret", w_instret, 32'd5);

        // D: branches
        clr_imem();
        imem[0] = e_addi(1, 0, 5);
        imem[1] = e_b(1, 1, 8, 3'd0);
        imem[3] = e_b(1, 1, 8, 3'd1);
        imem[4] = e_addi(30, 0, 1);
        iwait = 0;
        do_reset();
        wait_halt(60, ncyc);
`ifdef MC_CORE_BRANCH_EN
        chk("D_beq_cpi", ret_cyc[2] - ret_cyc[1], 32'd3);
        chk("D_beq_pc", ret_pc[2], 32'd12);
        chk("D_bne_pc", ret_pc[3], 32'd16);
        chk("D_illegal", {31'd0, w_illegal}, 32'd0);
        chk("D_instret", w_instret, 32'd4);
        chk("D_pc", w_pc, 32'd16);
`else
        chk("D_illegal", {31'd0, w_illegal}, 32'd1);
        chk("D_halted", {31'd0, w_halted}, 32'd1);
        chk("D_instret", w_instret, 32'd1);
        chk("D_pc", w_pc, 32'd4);
`endif

        // E: illegal opcode at PC 0
        clr_imem();
        do_reset();
        wait_halt(20, ncyc);
        chk("E_cycles", ncyc, 32'd2);
        chk("E_illegal", {31'd0, w_illegal}, 32'd1);
        chk("E_instret", w_instret, 32'd0);
        chk("E_pc", w_pc, 32'd0);
        req_snap = n_req;
        repeat (10) @(posedge w_clk);
        #1;
        chk("E_no_req", n_req - req_snap, 32'd0);

        // F: reset during a load wait
        clr_imem();
        imem[0] = e_addi(1, 0, 3);
        imem[1] = e_lw(4, 0, 8);
        dwait = 10;
        do_reset();
        for (int k = 0; k < 30; k++) begin
            @(negedge w_clk);
            if (bus.w_dmem_req) break;
        end
        chk("F_dreq_seen", {31'd0, bus.w_dmem_req}, 32'd1);
        @(posedge w_clk);
        #2;
        w_rst = 1'b1;
        #1;
        chk("F_dreq_drop", {31'd0, bus.w_dmem_req}, 32'd0);
        chk("F_ireq_rst", {31'd0, bus.w_imem_req}, 32'd0);
        chk("F_pc", w_pc, 32'd0);
        chk("F_x1", dut.regs[1], 32'd0);
        dwait = 0;
        @(negedge w_clk);
        w_rst = 1'b0;
        #1;
        chk("F_refetch", {31'd0, bus.w_imem_req}, 32'd1);
        chk("F_refetch_addr", bus.w_imem_addr, 32'd0);
        wait_halt(40, ncyc);
        chk("F_x1_rerun", dut.regs[1], 32'd3);
        chk("F_x4_rerun", dut.regs[4], 32'd7);
        chk("F_instret", w_instret, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
